ball_motion_engine: RTL

- Owns ball kinematics for the pong game in the slow game-logic clock domain.
- Steps the ball one pixel per axis every move period, bounces it off the top/bottom borders and both paddles, detects scoring at the left/right borders, and re-serves from centre after a delay.
- Consumes paddle positions from the paddle logic in the same domain.
- Produces ball_pos_x/ball_pos_y for the clock-domain handshake into the graphics path.

---
 rtl/ball_motion_engine.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ball_motion_engine.sv
// ball_motion_engine: pong ball stepping, wall/paddle bounces, scoring and timed re-serve.
// Define BALL_SPEEDUP_EN to shorten the step period on every paddle hit.
module ball_motion_engine #(
  parameter int TOTAL_WIDTH = 640,
  parameter int TOTAL_HEIGHT = 480,
  parameter int PADDLE_WIDTH = 8,
  parameter int PADDLE_HEIGHT = 64,
  parameter int PADDLE_1_X = 16,
  parameter int PADDLE_2_X = 616,
  parameter int BALL_SIDE_SIZE = 8,
  parameter int BORDER_PIXEL_WIDTH = 4,
  parameter int INITIAL_BALL_X = 316,
  parameter int INITIAL_BALL_Y = 236,
  parameter int BALL_OFFSET_RANGE = 16,
  parameter int MOVE_PERIOD_IN_CLOCKS = 40,
  parameter int SERVE_DELAY_IN_CLOCKS = 10000,
  parameter int SPEEDUP_STEP_IN_CLOCKS = 2,
  parameter int MIN_MOVE_PERIOD_IN_CLOCKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic [$clog2(TOTAL_HEIGHT+1):0] paddle_1_pos,
  input  logic [$clog2(TOTAL_HEIGHT+1):0] paddle_2_pos,
  output logic [$clog2(TOTAL_WIDTH+1):0] ball_pos_x,
  output logic [$clog2(TOTAL_HEIGHT+1):0] ball_pos_y,
  output logic ball_dir_x,
  output logic ball_dir_y,
  output logic point_p1,
  output logic point_p2,
  output logic serving
);
  localparam int XW = $clog2(TOTAL_WIDTH+1) + 1;
  localparam int YW = $clog2(TOTAL_HEIGHT+1) + 1;
  localparam int XE = XW + 1;
  localparam int YE = YW + 1;
  localparam int PCW = $clog2(MOVE_PERIOD_IN_CLOCKS+1);
  localparam int DCW = $clog2(SERVE_DELAY_IN_CLOCKS+1);
  if (MOVE_PERIOD_IN_CLOCKS < 2 || MIN_MOVE_PERIOD_IN_CLOCKS < 1 || SPEEDUP_STEP_IN_CLOCKS < 0) begin : g_bad_params
    $error("ball_motion_engine: invalid move period parameters");
  end
  typedef enum logic [1:0] {SERVE_WAIT, MOVING, SCORED} state_t;
  state_t state;
  logic [7:0] lfsr;
  logic [DCW-1:0] delay_cnt;
  logic [PCW-1:0] step_cnt;
  logic [PCW-1:0] per;
  logic [XE-1:0] xe;
  logic [YE-1:0] ye, p1e, p2e;
  logic [YW-1:0] serve_y;
  logic step, y_flip, hit_r, hit_l, hit, score_r, score_l;
  assign xe = {1'b0, ball_pos_x};
  assign ye = {1'b0, ball_pos_y};
  assign p1e = {1'b0, paddle_1_pos};
  assign p2e = {1'b0, paddle_2_pos};
  assign serve_y = YW'(INITIAL_BALL_Y) + YW'(32'(lfsr) % (BALL_OFFSET_RANGE + 1));
  assign step = step_cnt == per - PCW'(1);
  assign y_flip = ball_dir_y ? ye + YE'(BALL_SIDE_SIZE) >= YE'(TOTAL_HEIGHT - BORDER_PIXEL_WIDTH)
                             : ye <= YE'(BORDER_PIXEL_WIDTH);
  assign hit_r = ball_dir_x && xe + XE'(BALL_SIDE_SIZE) == XE'(PADDLE_2_X)
                 && ye < p2e + YE'(PADDLE_HEIGHT) && ye + YE'(BALL_SIDE_SIZE) > p2e;
  assign hit_l = !ball_dir_x && xe == XE'(PADDLE_1_X + PADDLE_WIDTH)
                 && ye < p1e + YE'(PADDLE_HEIGHT) && ye + YE'(BALL_SIDE_SIZE) > p1e;
  assign hit = hit_r || hit_l;
  assign score_r = ball_dir_x && xe + XE'(BALL_SIDE_SIZE) >= XE'(TOTAL_WIDTH - BORDER_PIXEL_WIDTH);
  assign score_l = !ball_dir_x && xe <= XE'(BORDER_PIXEL_WIDTH);
`ifdef BALL_SPEEDUP_EN
  always_ff @(posedge clk)
    if (rst || state == SCORED)
      per <= PCW'(MOVE_PERIOD_IN_CLOCKS);
    else if (state == MOVING && step && hit)
      per <= int'(per) > MIN_MOVE_PERIOD_IN_CLOCKS + SPEEDUP_STEP_IN_CLOCKS
             ? per - PCW'(SPEEDUP_STEP_IN_CLOCKS) : PCW'(MIN_MOVE_PERIOD_IN_CLOCKS);
`else
  assign per = PCW'(MOVE_PERIOD_IN_CLOCKS);
`endif
  always_ff @(posedge clk)
    if (rst) lfsr <= 8'hA5;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SERVE_WAIT;
      ball_pos_x <= XW'(INITIAL_BALL_X);
      ball_pos_y <= YW'(INITIAL_BALL_Y);
      ball_dir_x <= 1'b1;
      ball_dir_y <= 1'b1;
      point_p1 <= 1'b0;
      point_p2 <= 1'b0;
      serving <= 1'b1;
      delay_cnt <= '0;
      step_cnt <= '0;
    end else begin
      point_p1 <= 1'b0;
      point_p2 <= 1'b0;
      case (state)
        SERVE_WAIT:
          if (delay_cnt == DCW'(SERVE_DELAY_IN_CLOCKS - 1)) begin
            state <= MOVING;
            serving <= 1'b0;
            delay_cnt <= '0;
            step_cnt <= '0;
          end else delay_cnt <= delay_cnt + DCW'(1);
        MOVING:
          if (!step) step_cnt <= step_cnt + PCW'(1);
          else begin
            step_cnt <= '0;
            // a score freezes the ball, including its pending y move
            if (!hit && (score_r || score_l)) begin
              state <= SCORED;
              point_p1 <= score_r;
              point_p2 <= score_l;
            end else begin
              ball_dir_x <= ball_dir_x ^ hit;
              ball_pos_x <= hit ? ball_pos_x : ball_dir_x ? ball_pos_x + XW'(1) : ball_pos_x - XW'(1);
              ball_dir_y <= ball_dir_y ^ y_flip;
              ball_pos_y <= y_flip ? ball_pos_y : ball_dir_y ? ball_pos_y + YW'(1) : ball_pos_y - YW'(1);
            end
          end
        default: begin
          state <= SERVE_WAIT;
          serving <= 1'b1;
          delay_cnt <= '0;
          ball_pos_x <= XW'(INITIAL_BALL_X);
          ball_pos_y <= serve_y;
          ball_dir_y <= lfsr[0];
          ball_dir_x <= point_p1;
        end
      endcase
    end
  end
endmodule
